// File: rtl/bus_initiator_if.sv
// Core load/store request/response and word-wide memory bus signals of the bus initiator.
// The initiator uses the master modport; the core and responder side uses slave.
interface bus_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_address;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_data;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_data;
    logic        bus_cs;
    logic [29:0] bus_address;
    logic [31:0] bus_data_out;
    logic [3:0]  bus_data_strobes;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_data_in;

    modport master (
        input  req_valid, req_write, req_address, req_size, req_signed, req_data, bus_data_in,
        output req_ready, resp_valid, resp_error, resp_data,
               bus_cs, bus_address, bus_data_out, bus_data_strobes, bus_read, bus_write
    );

    modport slave (
        output req_valid, req_write, req_address, req_size, req_signed, req_data, bus_data_in,
        input  req_ready, resp_valid, resp_error, resp_data,
               bus_cs, bus_address, bus_data_out, bus_data_strobes, bus_read, bus_write
    );
endinterface

// File: rtl/bus_initiator.sv
// Big-endian bus master: one byte/halfword/word load or store per transaction, IDLE -> ACCESS -> DONE.
// Misaligned or reserved-size requests skip the bus and go straight to an error response.
module bus_initiator #(
    parameter int unsigned WAIT_STATES = 0
) (
    input logic             clock,
    input logic             reset,
    bus_initiator_if.master bif
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_e;

    typedef struct packed {
        logic       write;
        logic [1:0] lane;
        logic [1:0] size;
        logic       sext;
    } req_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_error_q, resp_error_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        bus_cs_q, bus_cs_d;
    logic [29:0] bus_address_q, bus_address_d;
    logic [31:0] bus_data_out_q, bus_data_out_d;
    logic [3:0]  bus_data_strobes_q, bus_data_strobes_d;
    logic        bus_read_q, bus_read_d;
    logic        bus_write_q, bus_write_d;

    logic        accept, bad_req, capture;
    logic [3:0]  strobes_new;
    logic [31:0] wdata_new, load_val;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign accept  = bif.req_valid & req_ready_q;
    assign capture = (state_q == ACCESS) && (state_d == DONE);

    always_comb begin
        case (bif.req_size)
            2'b00:   bad_req = 1'b0;
            2'b01:   bad_req = bif.req_address[0];
            2'b10:   bad_req = |bif.req_address[1:0];
            default: bad_req = 1'b1;
        endcase
    end

    // Lane 3 carries the lowest byte address (big-endian).
    always_comb begin
        strobes_new = 4'b0000;
        wdata_new   = bif.req_data;
        case (bif.req_size)
            2'b00: begin
                strobes_new = 4'b1000 >> bif.req_address[1:0];
                wdata_new   = {4{bif.req_data[7:0]}};
            end
            2'b01: begin
                strobes_new = bif.req_address[1] ? 4'b0011 : 4'b1100;
                wdata_new   = {2{bif.req_data[15:0]}};
            end
            2'b10:   strobes_new = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        case (req_q.lane)
            2'd0:    byte_sel = bif.bus_data_in[31:24];
            2'd1:    byte_sel = bif.bus_data_in[23:16];
            2'd2:    byte_sel = bif.bus_data_in[15:8];
            default: byte_sel = bif.bus_data_in[7:0];
        endcase
        half_sel = req_q.lane[1] ? bif.bus_data_in[15:0] : bif.bus_data_in[31:16];
        case (req_q.size)
            2'b00:   load_val = {{24{req_q.sext & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{req_q.sext & half_sel[15]}}, half_sel};
            default: load_val = bif.bus_data_in;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d   = '{write: bif.req_write, lane: bif.req_address[1:0],
                                size: bif.req_size, sext: bif.req_signed};
                    cnt_d   = WAIT_INIT;
                    state_d = bad_req ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are computed from the next state.
    always_comb begin
        req_ready_d        = (state_d == IDLE);
        resp_valid_d       = (state_d == DONE);
        resp_error_d       = (state_q == IDLE) && (state_d == DONE);
        resp_data_d        = (capture && !req_q.write) ? load_val : resp_data_q;
        bus_cs_d           = (state_d == ACCESS);
        bus_read_d         = (state_d == ACCESS) && !req_d.write;
        bus_write_d        = (state_d == ACCESS) && req_d.write;
        bus_address_d      = bus_address_q;
        bus_data_out_d     = bus_data_out_q;
        bus_data_strobes_d = (state_d == ACCESS) ? bus_data_strobes_q : 4'b0000;
        if ((state_q == IDLE) && (state_d == ACCESS)) begin
            bus_address_d      = bif.req_address[31:2];
            bus_data_out_d     = wdata_new;
            bus_data_strobes_d = strobes_new;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            req_ready_q        <= 1'b1;
            resp_valid_q       <= 1'b0;
            resp_error_q       <= 1'b0;
            resp_data_q        <= '0;
            bus_cs_q           <= 1'b0;
            bus_address_q      <= '0;
            bus_data_out_q     <= '0;
            bus_data_strobes_q <= '0;
            bus_read_q         <= 1'b0;
            bus_write_q        <= 1'b0;
        end else begin
            req_ready_q        <= req_ready_d;
            resp_valid_q       <= resp_valid_d;
            resp_error_q       <= resp_error_d;
            resp_data_q        <= resp_data_d;
            bus_cs_q           <= bus_cs_d;
            bus_address_q      <= bus_address_d;
            bus_data_out_q     <= bus_data_out_d;
            bus_data_strobes_q <= bus_data_strobes_d;
            bus_read_q         <= bus_read_d;
            bus_write_q        <= bus_write_d;
        end
    end

    assign bif.req_ready        = req_ready_q;
    assign bif.resp_valid       = resp_valid_q;
    assign bif.resp_error       = resp_error_q;
    assign bif.resp_data        = resp_data_q;
    assign bif.bus_cs           = bus_cs_q;
    assign bif.bus_address      = bus_address_q;
    assign bif.bus_data_out     = bus_data_out_q;
    assign bif.bus_data_strobes = bus_data_strobes_q;
    assign bif.bus_read         = bus_read_q;
    assign bif.bus_write        = bus_write_q;
endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: table of load/store vectors on a zero-wait instance with a
// response scoreboard, plus hand sequences for busy requests, mid-access reset and a two-wait-state instance.
`timescale 1ns/1ps
module tb_bus_initiator;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    bus_initiator_if bif0 ();
    bus_initiator_if bif2 ();

    bus_initiator #(.WAIT_STATES(0)) u_dut0 (.clock(clock), .reset(reset), .bif(bif0.master));
    bus_initiator #(.WAIT_STATES(2)) u_dut2 (.clock(clock), .reset(reset), .bif(bif2.master));

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
        logic        err;
        logic [3:0]  strb;
        logic [31:0] bus_d;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem0 [0:255];
    int          cs2_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                                input logic s, input logic [31:0] d, input logic e,
                                input logic [3:0] st, input logic [31:0] bd, input logic [31:0] rd);
        vec_t v;
        v.wr = wr; v.addr = a; v.size = sz; v.sgn = s; v.wdata = d;
        v.err = e; v.strb = st; v.bus_d = bd; v.rdata = rd;
        return v;
    endfunction

    // Responder for the zero-wait instance: merges strobed writes, presents the word on negedge.
    always @(negedge clock) begin : resp0
        logic [31:0] w;
        w = mem0[bif0.bus_address[7:0]];
        if (bif0.bus_cs === 1'b1 && bif0.bus_write === 1'b1)
            for (int b = 0; b < 4; b++)
                if (bif0.bus_data_strobes[b]) w[8*b +: 8] = bif0.bus_data_out[8*b +: 8];
        mem0[bif0.bus_address[7:0]] <= w;
        bif0.bus_data_in <= w;
    end

    // Two-wait responder: valid data only appears on the third negedge of cs, poison before that.
    always @(negedge clock) begin
        if (bif2.bus_cs === 1'b1) begin
            cs2_cnt <= cs2_cnt + 1;
            bif2.bus_data_in <= (cs2_cnt == 2) ? 32'hCAFEF00D : 32'hBAD0BAD0;
        end else begin
            cs2_cnt <= 0;
            bif2.bus_data_in <= 32'hBAD0BAD0;
        end
    end

    always @(negedge clock) begin
        if (bif0.resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response pending");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("resp_error", 32'(bif0.resp_error), 32'(e.err));
                check("resp_data", bif0.resp_data, e.rdata);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        check({tag, "_ready"},  32'(bif0.req_ready), 32'd1);
        check({tag, "_rvalid"}, 32'(bif0.resp_valid), 32'd0);
        check({tag, "_rerror"}, 32'(bif0.resp_error), 32'd0);
        check({tag, "_rdata"},  bif0.resp_data, 32'd0);
        check({tag, "_cs"},     32'(bif0.bus_cs), 32'd0);
        check({tag, "_rw"},     32'({bif0.bus_read, bif0.bus_write}), 32'd0);
        check({tag, "_addr"},   32'(bif0.bus_address), 32'd0);
        check({tag, "_dout"},   bif0.bus_data_out, 32'd0);
        check({tag, "_strb"},   32'(bif0.bus_data_strobes), 32'd0);
    endtask

    task automatic drive0(input vec_t v);
        bif0.req_valid   = 1'b1;
        bif0.req_write   = v.wr;
        bif0.req_address = v.addr;
        bif0.req_size    = v.size;
        bif0.req_signed  = v.sgn;
        bif0.req_data    = v.wdata;
    endtask

    task automatic scramble0();
        bif0.req_valid   = 1'b0;
        bif0.req_write   = 1'($urandom);
        bif0.req_address = $urandom;
        bif0.req_size    = 2'($urandom);
        bif0.req_signed  = 1'($urandom);
        bif0.req_data    = $urandom;
    endtask

    task automatic wait_ready0(input string tag);
        int n;
        n = 0;
        while (bif0.req_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_ready"}, 32'(bif0.req_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   cs_cycles;
        int   n;
        exp_t e;
        wait_ready0(tag);
        drive0(v);
        e.err = v.err;
        e.rdata = v.rdata;
        sb_q.push_back(e);
        @(negedge clock);
        scramble0();
        cs_cycles = 0;
        n = 0;
        while (bif0.resp_valid !== 1'b1 && n < 40) begin
            if (bif0.bus_cs === 1'b1) begin
                cs_cycles++;
                check({tag, "_addr"}, 32'(bif0.bus_address), 32'(v.addr[31:2]));
                check({tag, "_strb"}, 32'(bif0.bus_data_strobes), 32'(v.strb));
                check({tag, "_rw"}, 32'({bif0.bus_read, bif0.bus_write}), 32'({~v.wr, v.wr}));
                if (v.wr) check({tag, "_dout"}, bif0.bus_data_out, v.bus_d);
            end
            @(negedge clock);
            n++;
        end
        check({tag, "_resp_seen"}, 32'(bif0.resp_valid), 32'd1);
        check({tag, "_cs_cycles"}, 32'(cs_cycles), v.err ? 32'd0 : 32'd1);
        check({tag, "_done_ready"}, 32'(bif0.req_ready), 32'd0);
        check({tag, "_done_bus"}, 32'({bif0.bus_cs, bif0.bus_read, bif0.bus_write, bif0.bus_data_strobes}), 32'd0);
        @(negedge clock);
        check({tag, "_pulse"}, 32'(bif0.resp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(bif0.req_ready), 32'd1);
    endtask

    initial begin
        vec_t vecs [16];
        vec_t v;
        int   n, cs_cnt;

        for (int k = 0; k < 256; k++) mem0[k] = 32'h0;
        mem0[8'h40] = 32'h12F45678;
        mem0[8'h80] = 32'h11223344;
        scramble0();
        bif2.req_valid = 1'b0; bif2.req_write = 1'b0; bif2.req_address = 32'h0;
        bif2.req_size = 2'b10; bif2.req_signed = 1'b0; bif2.req_data = 32'h0;

        //                 wr    addr     size   sgn   wdata         err   strb     bus_d         rdata
        vecs[0]  = mk(1'b0, 32'h101, 2'b00, 1'b1, 32'h0,        1'b0, 4'b0100, 32'h0,        32'hFFFFFFF4);
        vecs[1]  = mk(1'b0, 32'h101, 2'b00, 1'b0, 32'h0,        1'b0, 4'b0100, 32'h0,        32'h000000F4);
        vecs[2]  = mk(1'b1, 32'h100, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h000000F4);
        vecs[3]  = mk(1'b0, 32'h100, 2'b10, 1'b0, 32'h0,        1'b0, 4'b1111, 32'h0,        32'hDEADBEEF);
        vecs[4]  = mk(1'b1, 32'h202, 2'b01, 1'b0, 32'h0000ABCD, 1'b0, 4'b0011, 32'hABCDABCD, 32'hDEADBEEF);
        vecs[5]  = mk(1'b0, 32'h200, 2'b10, 1'b0, 32'h0,        1'b0, 4'b1111, 32'h0,        32'h1122ABCD);
        vecs[6]  = mk(1'b0, 32'h103, 2'b10, 1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h1122ABCD);
        vecs[7]  = mk(1'b0, 32'h200, 2'b11, 1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h1122ABCD);
        vecs[8]  = mk(1'b0, 32'h202, 2'b01, 1'b1, 32'h0,        1'b0, 4'b0011, 32'h0,        32'hFFFFABCD);
        vecs[9]  = mk(1'b0, 32'h202, 2'b01, 1'b0, 32'h0,        1'b0, 4'b0011, 32'h0,        32'h0000ABCD);
        vecs[10] = mk(1'b1, 32'h103, 2'b00, 1'b0, 32'h0000005A, 1'b0, 4'b0001, 32'h5A5A5A5A, 32'h0000ABCD);
        vecs[11] = mk(1'b0, 32'h100, 2'b10, 1'b0, 32'h0,        1'b0, 4'b1111, 32'h0,        32'hDEADBE5A);
        vecs[12] = mk(1'b1, 32'h201, 2'b01, 1'b0, 32'h00001234, 1'b1, 4'b0000, 32'h0,        32'hDEADBE5A);
        vecs[13] = mk(1'b0, 32'h100, 2'b00, 1'b1, 32'h0,        1'b0, 4'b1000, 32'h0,        32'hFFFFFFDE);
        vecs[14] = mk(1'b0, 32'h102, 2'b00, 1'b0, 32'h0,        1'b0, 4'b0010, 32'h0,        32'h000000BE);
        vecs[15] = mk(1'b0, 32'h200, 2'b01, 1'b0, 32'h0,        1'b0, 4'b1100, 32'h0,        32'h00001122);

        repeat (3) @(negedge clock);
        chk_reset_vals("rst_init");
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Request held high through ACCESS and DONE must be taken exactly once.
        wait_ready0("busy");
        drive0(mk(1'b0, 32'h200, 2'b10, 1'b0, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h1122ABCD));
        begin
            exp_t e;
            e.err = 1'b0;
            e.rdata = 32'h1122ABCD;
            sb_q.push_back(e);
        end
        repeat (2) @(negedge clock);
        scramble0();
        repeat (5) @(negedge clock);
        check("busy_single_resp", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of a store access: no response, reset values next edge.
        wait_ready0("midrst");
        drive0(mk(1'b1, 32'h300, 2'b10, 1'b0, 32'h55AA55AA, 1'b0, 4'b1111, 32'h55AA55AA, 32'h0));
        @(negedge clock);
        scramble0();
        check("midrst_cs", 32'(bif0.bus_cs), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk_reset_vals("midrst");
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("midrst_no_resp", 32'(bif0.resp_valid), 32'd0);
        end
        run_vec(mk(1'b0, 32'h200, 2'b10, 1'b0, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h1122ABCD), "postrst_ld");
        run_vec(mk(1'b0, 32'h201, 2'b01, 1'b0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h1122ABCD), "postrst_err");

        // Two wait states: cs/read for three cycles, data taken at the end of the third.
        check("ws2_ready", 32'(bif2.req_ready), 32'd1);
        bif2.req_valid = 1'b1; bif2.req_write = 1'b0; bif2.req_address = 32'h100;
        bif2.req_size = 2'b10; bif2.req_signed = 1'b0;
        @(negedge clock);
        bif2.req_valid = 1'b0; bif2.req_address = 32'hFFFF_FFFC;
        n = 0;
        cs_cnt = 0;
        while (bif2.resp_valid !== 1'b1 && n < 40) begin
            if (bif2.bus_cs === 1'b1) begin
                cs_cnt++;
                check("ws2_rw", 32'({bif2.bus_read, bif2.bus_write}), 32'b10);
                check("ws2_addr", 32'(bif2.bus_address), 32'h40);
            end
            @(negedge clock);
            n++;
        end
        check("ws2_cs_cycles", 32'(cs_cnt), 32'd3);
        check("ws2_resp_seen", 32'(bif2.resp_valid), 32'd1);
        check("ws2_cs_off", 32'(bif2.bus_cs), 32'd0);
        check("ws2_rerror", 32'(bif2.resp_error), 32'd0);
        check("ws2_rdata", bif2.resp_data, 32'hCAFEF00D);
        @(negedge clock);
        check("ws2_pulse", 32'(bif2.resp_valid), 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
